alu_op_issue: RTL and testbench

//  Upstream issue stage for the 8-bit ALU. Buffers {sel,A,B} instructions from a producer
//  (valid/ready) in a small FIFO and drives ALU operand/select inputs one instruction per issue.
//  The ALU re-executes its select on every clk edge, so when not issuing this block drives a

---
 rtl/alu_pkg.sv | 52 +++++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/alu_op_issue.sv | 144 ++++++++++++++
 tb/tb_alu_op_issue.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage.
//  - ALU_OP_* : all 16 ALU select encodings
//  - HOLD_*   : the result-preserving idle instruction (ADD_A with A=0)
//  - alu_instr_t : one queued {sel,a,b} instruction
//  - issue_state_e : action taken by the issue logic at the last edge
package alu_pkg;

  localparam int DATA_W     = 8;
  localparam int SEL_W      = 4;
  localparam int FIFO_DEPTH = 4;

  localparam logic [SEL_W-1:0] ALU_OP_ADD    = 4'b0000;
  localparam logic [SEL_W-1:0] ALU_OP_SUB    = 4'b0001;
  localparam logic [SEL_W-1:0] ALU_OP_MUL    = 4'b0010;
  localparam logic [SEL_W-1:0] ALU_OP_DIV    = 4'b0011;
  localparam logic [SEL_W-1:0] ALU_OP_ADD_A  = 4'b0100;
  localparam logic [SEL_W-1:0] ALU_OP_SUB_A  = 4'b0101;
  localparam logic [SEL_W-1:0] ALU_OP_MAC    = 4'b0110;
  localparam logic [SEL_W-1:0] ALU_OP_AND    = 4'b0111;
  localparam logic [SEL_W-1:0] ALU_OP_OR     = 4'b1000;
  localparam logic [SEL_W-1:0] ALU_OP_XOR    = 4'b1001;
  localparam logic [SEL_W-1:0] ALU_OP_NOT    = 4'b1010;
  localparam logic [SEL_W-1:0] ALU_OP_SHL    = 4'b1011;
  localparam logic [SEL_W-1:0] ALU_OP_SHR    = 4'b1100;
  localparam logic [SEL_W-1:0] ALU_OP_CMP    = 4'b1101;
  localparam logic [SEL_W-1:0] ALU_OP_PASS_A = 4'b1110;
  localparam logic [SEL_W-1:0] ALU_OP_PASS_B = 4'b1111;

  // The ALU executes its select on every edge; accumulating zero keeps
  // the previous result intact while nothing is being issued.
  localparam logic [SEL_W-1:0]  HOLD_SEL = ALU_OP_ADD_A;
  localparam logic [DATA_W-1:0] HOLD_A   = '0;
  localparam logic [DATA_W-1:0] HOLD_B   = '0;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } alu_instr_t;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,  // nothing issued
    ST_ISSUE = 2'd1,  // head instruction driven to the ALU
    ST_DROP  = 2'd2,  // head was DIV by zero and was discarded
    ST_FLUSH = 2'd3   // queue discarded
  } issue_state_e;

  function automatic logic is_divz(input alu_instr_t instr);
    return (instr.sel == ALU_OP_DIV) && (instr.b == '0);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, single clock, no read bypass: a word written at edge N
// is visible on rdata from edge N+1.
// Ports:
//  clk, rst (sync active-high), flush (empties the FIFO)
//  push/wdata : write when push && !full
//  pop/rdata  : rdata is the head; pop advances when !empty
//  full, empty, count (log2(DEPTH)+1 bits)
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_MAX);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage needs no reset: count gates every read that matters.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (do_push && !do_pop)      count_q <= count_q + CNT_ONE;
      else if (do_pop && !do_push) count_q <= count_q - CNT_ONE;
    end
  end

endmodule

// File: rtl/alu_op_issue.sv
// Issue stage in front of the 8-bit ALU. Queues {sel,a,b} instructions and
// drives the ALU select/operands one instruction per issue edge; otherwise
// drives the result-preserving HOLD op.
// Ports:
//  clk, rst (sync active-high)
//  in_valid/in_ready/in_sel/in_a/in_b : producer instruction stream
//  stall   : 1 = do not issue at this edge
//  flush   : discard every queued instruction
//  clr_err : clear err_divz (a simultaneous divide-by-zero drop wins)
//  alu_sel/alu_a/alu_b : registered ALU inputs
//  alu_issue : alu_* hold a real instruction this cycle
//  res_valid/res_sel : ALU output holds the result of res_sel this cycle
//  err_divz  : sticky, a DIV with B==0 was dropped
//  issue_cnt : issued-instruction count, wraps
//  dbg_state/dbg_count : action taken at the last edge / FIFO occupancy
//
// Handshake: an instruction transfers at a rising edge where in_valid and
// in_ready are both 1; in_ready does not depend on in_valid. Transfers are
// refused while rst or flush is high.
module alu_op_issue
  import alu_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              stall,
  input  logic              flush,
  input  logic              clr_err,
  output logic [SEL_W-1:0]  alu_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_issue,
  output logic              res_valid,
  output logic [SEL_W-1:0]  res_sel,
  output logic              err_divz,
  output logic [15:0]       issue_cnt,
  output issue_state_e      dbg_state,
  output logic [CNT_W-1:0]  dbg_count
);

  alu_instr_t        wr_instr, head;
  logic              full, empty, push, pop;
  logic [CNT_W-1:0]  fifo_count;

  issue_state_e      state_q, state_d;
  logic [SEL_W-1:0]  alu_sel_q, alu_sel_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic              res_valid_q;
  logic [SEL_W-1:0]  res_sel_q;
  logic              err_q, err_d;
  logic [15:0]       cnt_q, cnt_d;

  assign in_ready = !rst && !full;
  assign push     = in_valid && in_ready && !flush;
  assign wr_instr = '{sel: in_sel, a: in_a, b: in_b};

  sync_fifo #(
    .WIDTH ($bits(alu_instr_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .wdata (wr_instr),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d   = ST_HOLD;
    alu_sel_d = HOLD_SEL;
    alu_a_d   = HOLD_A;
    alu_b_d   = HOLD_B;
    err_d     = err_q;
    cnt_d     = cnt_q;
    if (flush) begin
      state_d = ST_FLUSH;
    end else if (!empty && !stall) begin
      if (is_divz(head)) begin
        state_d = ST_DROP;
      end else begin
        state_d   = ST_ISSUE;
        alu_sel_d = head.sel;
        alu_a_d   = head.a;
        alu_b_d   = head.b;
        cnt_d     = cnt_q + 16'd1;
      end
    end
    // Setting on a drop takes precedence over clearing.
    if (state_d == ST_DROP) err_d = 1'b1;
    else if (clr_err)       err_d = 1'b0;
  end

  // A dropped DIV still leaves the queue.
  assign pop = (state_d == ST_ISSUE) || (state_d == ST_DROP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HOLD;
      alu_sel_q   <= HOLD_SEL;
      alu_a_q     <= HOLD_A;
      alu_b_q     <= HOLD_B;
      res_valid_q <= 1'b0;
      res_sel_q   <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q   <= state_d;
      alu_sel_q <= alu_sel_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      // The ALU captures the issued op at the next edge, so the result
      // becomes valid one edge after alu_issue.
      res_valid_q <= (state_q == ST_ISSUE);
      if (state_q == ST_ISSUE) res_sel_q <= alu_sel_q;
    end
  end

  assign alu_sel   = alu_sel_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_issue = (state_q == ST_ISSUE);
  assign res_valid = res_valid_q;
  assign res_sel   = res_sel_q;
  assign err_divz  = err_q;
  assign issue_cnt = cnt_q;
  assign dbg_state = state_q;
  assign dbg_count = fifo_count;

endmodule

// File: tb/tb_alu_op_issue.sv
module tb_alu_op_issue;
  import alu_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst, in_valid, stall, flush, clr_err;
  logic [3:0] in_sel;
  logic [7:0] in_a, in_b;
  logic       in_ready, alu_issue, res_valid, err_divz;
  logic [3:0] alu_sel, res_sel;
  logic [7:0] alu_a, alu_b;
  logic [15:0] issue_cnt;
  issue_state_e dbg_state;
  logic [2:0] dbg_count;

  always #5 clk = ~clk;

  alu_op_issue dut (
    .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready),
    .in_sel (in_sel), .in_a (in_a), .in_b (in_b), .stall (stall),
    .flush (flush), .clr_err (clr_err), .alu_sel (alu_sel), .alu_a (alu_a),
    .alu_b (alu_b), .alu_issue (alu_issue), .res_valid (res_valid),
    .res_sel (res_sel), .err_divz (err_divz), .issue_cnt (issue_cnt),
    .dbg_state (dbg_state), .dbg_count (dbg_count)
  );

  // Stand-in for the downstream ALU result register (ops used here only).
  logic [7:0] alu_res = 8'd0;
  always @(posedge clk) begin
    case (alu_sel)
      4'b0000: alu_res <= alu_a + alu_b;
      4'b0011: alu_res <= (alu_b != 8'd0) ? alu_a / alu_b : alu_res;
      4'b0100: alu_res <= alu_res + alu_a;
      4'b0110: alu_res <= alu_res + alu_a * alu_b;
      default: alu_res <= alu_res;
    endcase
  end

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] res_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [19:0] exp_q[$];   // queued {sel,a,b}
  logic        m_on = 1'b0;
  logic [3:0]  m_sel, m_rsel;
  logic [7:0]  m_a, m_b;
  logic        m_issue, m_rv, m_err;
  logic [15:0] m_cnt;

  // Outputs change only at posedge; inputs change 2ns after posedge.
  // At each negedge: compare against the model, then advance the model
  // with the inputs that the coming posedge will sample.
  initial begin
    forever begin
      @(negedge clk);
      if (m_on) begin
        chk("in_ready",  32'(in_ready),  32'(!rst && exp_q.size() < 4));
        chk("alu_sel",   32'(alu_sel),   32'(m_sel));
        chk("alu_a",     32'(alu_a),     32'(m_a));
        chk("alu_b",     32'(alu_b),     32'(m_b));
        chk("alu_issue", 32'(alu_issue), 32'(m_issue));
        chk("res_valid", 32'(res_valid), 32'(m_rv));
        chk("res_sel",   32'(res_sel),   32'(m_rsel));
        chk("err_divz",  32'(err_divz),  32'(m_err));
        chk("issue_cnt", 32'(issue_cnt), 32'(m_cnt));
        chk("count",     32'(dbg_count), 32'(exp_q.size()));
        if (res_valid === 1'b1) res_log.push_back(alu_res);
      end
      if (rst) begin
        exp_q.delete();
        m_sel = 4'b0100; m_a = 8'd0; m_b = 8'd0;
        m_issue = 1'b0; m_rv = 1'b0; m_rsel = 4'd0; m_err = 1'b0; m_cnt = 16'd0;
        m_on = 1'b1;
      end else if (m_on) begin
        logic        room, drop;
        logic [19:0] h;
        room = exp_q.size() < 4;
        drop = 1'b0;
        m_rv = m_issue;
        if (m_issue) m_rsel = m_sel;
        m_issue = 1'b0; m_sel = 4'b0100; m_a = 8'd0; m_b = 8'd0;
        if (flush) begin
          exp_q.delete();
        end else if (exp_q.size() > 0 && !stall) begin
          h = exp_q.pop_front();
          if (h[19:16] == 4'b0011 && h[7:0] == 8'd0) begin
            drop = 1'b1;
          end else begin
            m_issue = 1'b1;
            {m_sel, m_a, m_b} = h;
            m_cnt = m_cnt + 16'd1;
          end
        end
        if (drop) m_err = 1'b1;
        else if (clr_err) m_err = 1'b0;
        if (!flush && in_valid && room) exp_q.push_back({in_sel, in_a, in_b});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push_instr(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1; in_sel = s; in_a = a; in_b = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_results(input string name, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input int n);
    logic [7:0] exp_v[3];
    exp_v = '{e0, e1, e2};
    chk({name, "_n"}, 32'(res_log.size()), 32'(n));
    for (int i = 0; i < n && i < res_log.size(); i++)
      chk(name, 32'(res_log[i]), 32'(exp_v[i]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; clr_err = 1'b0;
    in_sel = 4'd0; in_a = 8'd0; in_b = 8'd0;
    tick(); tick();
    rst = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t1_sel",   32'(alu_sel),   32'h4);
      chk("t1_a",     32'(alu_a),     0);
      chk("t1_issue", 32'(alu_issue), 0);
      chk("t1_ready", 32'(in_ready),  1);
    end

    // 2: single ADD 3+4, latency
    push_instr(4'b0000, 8'd3, 8'd4);
    chk("t2_issue_n1", 32'(alu_issue), 0);
    tick();
    chk("t2_issue_n2", 32'(alu_issue), 1);
    chk("t2_a",        32'(alu_a),     3);
    chk("t2_b",        32'(alu_b),     4);
    tick();
    chk("t2_rv",       32'(res_valid), 1);
    chk("t2_rsel",     32'(res_sel),   0);
    chk("t2_res",      32'(alu_res),   7);
    chk("t2_cnt",      32'(issue_cnt), 1);
    idle(2);

    // 3: accumulate chain 5, 7, 19
    res_log.delete();
    push_instr(4'b0000, 8'd5, 8'd0);
    push_instr(4'b0100, 8'd2, 8'd0);
    push_instr(4'b0110, 8'd3, 8'd4);
    idle(5);
    chk_results("t3_res", 8'd5, 8'd7, 8'd19, 3);
    chk("t3_cnt", 32'(issue_cnt), 4);

    // 4: DIV by zero dropped, DIV 9/3 issued, clr_err
    res_log.delete();
    push_instr(4'b0011, 8'd9, 8'd0);
    push_instr(4'b0011, 8'd9, 8'd3);
    idle(5);
    chk("t4_err", 32'(err_divz), 1);
    chk_results("t4_res", 8'd3, 8'd0, 8'd0, 1);
    chk("t4_cnt", 32'(issue_cnt), 5);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("t4_clr", 32'(err_divz), 0);

    // 4b: drop on the same edge as clr_err -> set wins
    clr_err = 1'b1;
    push_instr(4'b0011, 8'd1, 8'd0);
    tick();
    chk("t4_setwins", 32'(err_divz), 1);
    clr_err = 1'b0;
    idle(2);
    chk("t4_sticky", 32'(err_divz), 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("t4_clr2", 32'(err_divz), 0);

    // 5: fill under stall, overflow attempt, flush
    stall = 1'b1;
    for (int i = 1; i <= 4; i++) push_instr(4'b0000, 8'(i), 8'd1);
    chk("t5_full_ready", 32'(in_ready),  0);
    chk("t5_full_count", 32'(dbg_count), 4);
    push_instr(4'b0000, 8'd99, 8'd1);
    chk("t5_no_push", 32'(dbg_count), 4);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t5_flush_count", 32'(dbg_count), 0);
    chk("t5_flush_ready", 32'(in_ready),  1);
    stall = 1'b0;
    idle(4);
    chk("t5_cnt", 32'(issue_cnt), 5);

    // 6: reset mid-stream with 3 queued
    stall = 1'b1;
    for (int i = 0; i < 3; i++) push_instr(4'b0000, 8'(i + 10), 8'd2);
    stall = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_sel",   32'(alu_sel),   32'h4);
    chk("t6_a",     32'(alu_a),     0);
    chk("t6_cnt",   32'(issue_cnt), 0);
    chk("t6_rv",    32'(res_valid), 0);
    chk("t6_count", 32'(dbg_count), 0);
    idle(4);
    chk("t6_cnt_after", 32'(issue_cnt), 0);

    // 7: streaming push/pop on the same edge
    res_log.delete();
    push_instr(4'b0000, 8'd1, 8'd1);
    push_instr(4'b0000, 8'd2, 8'd2);
    push_instr(4'b0000, 8'd3, 8'd3);
    idle(4);
    chk_results("t7_res", 8'd2, 8'd4, 8'd6, 3);
    chk("t7_cnt", 32'(issue_cnt), 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
